// File: rtl/alu_pkg.sv
// Shared types and constants for the bit-serial ALU sequencer and its 1-bit slice.
// Optional feature macro: ALU_SERIAL_OVF_EN (adds the signed-overflow flag to the sequencer).
package alu_pkg;

  // 3-bit operation encoding shared with the multicycle MIPS ALU slice.
  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_XOR = 3'b011,
    OP_RSV = 3'b100,
    OP_NOR = 3'b101,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } alu_op_t;

  localparam logic [2:0] ALU_OP_AND = 3'b000;
  localparam logic [2:0] ALU_OP_OR  = 3'b001;
  localparam logic [2:0] ALU_OP_ADD = 3'b010;
  localparam logic [2:0] ALU_OP_XOR = 3'b011;
  localparam logic [2:0] ALU_OP_RSV = 3'b100;
  localparam logic [2:0] ALU_OP_NOR = 3'b101;
  localparam logic [2:0] ALU_OP_SUB = 3'b110;
  localparam logic [2:0] ALU_OP_SLT = 3'b111;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Bit counter width for a WIDTH-bit operand (WIDTH >= 2).
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

  // Majority of three: the carry out of a full adder.
  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/alu_bit_core.sv
// Combinational 1-bit ALU slice: one bit of and/or/xor/nor/add/sub/slt.
// Subtract-like ops (sub, slt) invert b here; the caller seeds carry-in with 1.
module alu_bit_core
  import alu_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  input  logic       cin_i,
  input  logic [2:0] op_i,
  output logic       res_o,
  output logic       sum_o,
  output logic       cout_o
);

  logic b_eff;

  // Full adder on (a, possibly inverted b, cin) plus the per-op bit result.
  always_comb begin
    b_eff  = b_i ^ ((op_i == ALU_OP_SUB) || (op_i == ALU_OP_SLT));
    sum_o  = a_i ^ b_eff ^ cin_i;
    cout_o = maj3(a_i, b_eff, cin_i);
    res_o  = 1'b0;
    case (op_i)
      ALU_OP_AND: res_o = a_i & b_i;
      ALU_OP_OR:  res_o = a_i | b_i;
      ALU_OP_XOR: res_o = a_i ^ b_i;
      ALU_OP_NOR: res_o = ~(a_i | b_i);
      ALU_OP_ADD,
      ALU_OP_SUB: res_o = sum_o;
      default:    res_o = 1'b0; // slt is patched on the last bit; reserved gives 0
    endcase
  end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: accepts a WIDTH-bit op, evaluates it LSB-first one bit
// per cycle through alu_bit_core, returns result and zero flag.
// Handshakes: a transfer happens on a rising edge where valid && ready are both high;
// valid never depends on ready, and the sender holds its payload until the transfer.
// Optional macro ALU_SERIAL_OVF_EN adds the `overflow` output (signed overflow of add/sub).
module alu_serial_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic [1:0]       dbg_state
`ifdef ALU_SERIAL_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  seq_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
`ifdef ALU_SERIAL_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic bit_res, bit_sum, bit_cout;
  logic last_bit;
  logic slt_set;

  alu_bit_core u_bit (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .cin_i  (carry_q),
    .op_i   (op_q),
    .res_o  (bit_res),
    .sum_o  (bit_sum),
    .cout_o (bit_cout)
  );

  assign last_bit = (cnt_q == LAST_BIT);
  // Signed less-than: sign of a-b corrected by the MSB overflow term.
  assign slt_set  = bit_sum ^ (carry_q ^ bit_cout);

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
`ifdef ALU_SERIAL_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
`ifdef ALU_SERIAL_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Next-state: capture in IDLE, shift one bit per cycle in RUN, hold in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    zero_d  = zero_q;
`ifdef ALU_SERIAL_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          cnt_d   = '0;
          carry_d = op[2] & op[1];
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = bit_cout;
        cnt_d   = cnt_q + CW'(1);
        res_d   = {bit_res, res_q[WIDTH-1:1]};
        if (last_bit) begin
          if (op_q == ALU_OP_SLT) begin
            res_d = WIDTH'(slt_set);
          end
          zero_d  = (res_d == '0);
`ifdef ALU_SERIAL_OVF_EN
          ovf_d   = ((op_q == ALU_OP_ADD) || (op_q == ALU_OP_SUB)) & (carry_q ^ bit_cout);
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = res_q;
  assign zero      = zero_q;
  assign dbg_state = state_q;
`ifdef ALU_SERIAL_OVF_EN
  assign overflow  = ovf_q;
`endif

endmodule
